// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: operation codes, default latencies and the
// sequencer state type. Decode control imports the same package.
package mdu_ctrl_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MFHI  = 3'd4;
  localparam logic [2:0] MDU_MFLO  = 3'd5;
  localparam logic [2:0] MDU_MTHI  = 3'd6;
  localparam logic [2:0] MDU_MTLO  = 3'd7;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage MDU request/response bundle between the pipeline and mdu_ctrl.
interface mdu_ctrl_if;
  // Start is an issue qualifier with no ready: the hazard unit holds a
  // D-stage MDU instruction on MDUStall, so Start is only seen while Busy
  // when a stall was ignored, and is then dropped.
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        IntExcReq;
  logic        D_MDUClass;
  logic        Busy;
  logic        MDUStall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output Start, MDUOp, A, B, IntExcReq, D_MDUClass,
    input  Busy, MDUStall, HI, LO, MDUOut
  );

  modport slave (
    input  Start, MDUOp, A, B, IntExcReq, D_MDUClass,
    output Busy, MDUStall, HI, LO, MDUOut
  );
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational MDU datapath: 64-bit products, quotient/remainder and the
// divide-by-zero flag for the current E-stage operands.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    prod        = '0;
    a_mag       = a;
    b_mag       = b;
    q_mag       = '0;
    r_mag       = '0;
    res_hi      = '0;
    res_lo      = '0;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MDU_MULTU: begin
        prod   = {32'd0, a} * {32'd0, b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        // Signed divide works on magnitudes; 0x80000000 / -1 falls out as
        // quotient 0x80000000, remainder 0 with no special case.
        if (op == MDU_DIV) begin
          a_mag = a[31] ? (~a + 32'd1) : a;
          b_mag = b[31] ? (~b + 32'd1) : b;
        end
        div_by_zero = (b == 32'd0);
        if (!div_by_zero) begin
          q_mag = a_mag / b_mag;
          r_mag = a_mag % b_mag;
        end
        if (op == MDU_DIV) begin
          res_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
          res_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
        end else begin
          res_lo = q_mag;
          res_hi = r_mag;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, the busy counter and the
// MDU stall request. Results are computed at launch and retired N edges later.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   bus,
  output mdu_state_e  dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      phi_q, phi_d;
  logic [31:0]      plo_q, plo_d;
  logic             pwe_q, pwe_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;
  logic        busy;

  mdu_arith u_arith (
    .op          (bus.MDUOp),
    .a           (bus.A),
    .b           (bus.B),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  assign busy = (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      pwe_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      pwe_q <= pwe_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    pwe_d = pwe_q;
    if (busy) begin
      // An in-flight operation belongs to an older committed instruction, so
      // IntExcReq does not stop it; Start and MT are dropped meanwhile.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && pwe_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (!bus.IntExcReq) begin
      if (bus.Start) begin
        phi_d = res_hi;
        plo_d = res_lo;
        pwe_d = !div_by_zero;
        cnt_d = bus.MDUOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (bus.MDUOp == MDU_MTHI) begin
        hi_d = bus.A;
      end else if (bus.MDUOp == MDU_MTLO) begin
        lo_d = bus.A;
      end
    end
  end

  always_comb begin
    bus.Busy     = busy;
    bus.MDUStall = bus.D_MDUClass && (busy || bus.Start);
    bus.HI       = hi_q;
    bus.LO       = lo_q;
    bus.MDUOut   = '0;
    if (bus.MDUOp == MDU_MFHI)      bus.MDUOut = hi_q;
    else if (bus.MDUOp == MDU_MFLO) bus.MDUOut = lo_q;
    dbg_state    = busy ? ST_BUSY : ST_IDLE;
  end

endmodule
